uart_receiver: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_receiver.sv | 132 +++++++++++++
 tb/tb_uart_receiver.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
// Receiver state encoding, data width and default baud divisor live here.
package uart_pkg;

   localparam int UART_DATA_W       = 8;
   localparam int UART_CLKS_PER_BIT = 868;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to 1
// so an idle-high line is not mistaken for activity coming out of reset.
module uart_sync2 (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: recovers 8N1 frames from i_RX and strobes each byte out.
// Define UART_RX_PARITY_EN to add an even-parity bit and o_PARITY_ERROR.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic                   i_CLK,
   input  logic                   i_RESET_N,
   input  logic                   i_RX_ENABLE,
   input  logic                   i_RX,
   output logic [UART_DATA_W-1:0] o_DATA_OUT,
   output logic                   o_DATA_VALID,
   output logic                   o_FRAME_ERROR,
`ifdef UART_RX_PARITY_EN
   output logic                   o_PARITY_ERROR,
`endif
   output logic                   o_RX_BUSY,
   output logic [2:0]             o_STATE
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   localparam logic [2:0] ST_IDLE   = IDLE;
   localparam logic [2:0] ST_START  = START;
   localparam logic [2:0] ST_DATA   = DATA;
   localparam logic [2:0] ST_PARITY = PARITY;
   localparam logic [2:0] ST_STOP   = STOP;
   localparam logic [2:0] ST_BREAK  = BREAK;

`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
   localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

   logic                   rx_s;
   logic [2:0]             r_STATE;
   logic [2:0]             state_next;
   logic [CNT_W-1:0]       r_CLK_COUNT;
   logic [2:0]             r_BIT_COUNT;
   logic [UART_DATA_W-1:0] r_DATA_REG;
   logic                   at_half;
   logic                   at_last;
   logic                   data_sample;
   logic                   stop_sample;
`ifdef UART_RX_PARITY_EN
   logic                   r_PARITY_BIT;
`endif

   uart_sync2 u_rx_sync (
      .clk     (i_CLK),
      .reset_n (i_RESET_N),
      .d       (i_RX),
      .q       (rx_s)
   );

   assign at_half     = (r_CLK_COUNT == CNT_HALF);
   assign at_last     = (r_CLK_COUNT == CNT_LAST);
   assign data_sample = (r_STATE == ST_DATA) && at_last;
   assign stop_sample = (r_STATE == ST_STOP) && at_last;
   assign o_RX_BUSY   = (r_STATE != ST_IDLE);
   assign o_STATE     = r_STATE;

   always_comb begin
      state_next = r_STATE;
      case (r_STATE)
         ST_IDLE:   if (!rx_s && i_RX_ENABLE) state_next = ST_START;
         ST_START:  if (at_half) state_next = rx_s ? ST_IDLE : ST_DATA;
         ST_DATA:   if (at_last && (r_BIT_COUNT == 3'd7)) state_next = ST_AFTER_DATA;
         ST_PARITY: if (at_last) state_next = ST_STOP;
         // Leaving at mid-stop-bit leaves half a bit of slack for the next start edge.
         ST_STOP:   if (at_last) state_next = rx_s ? ST_IDLE : ST_BREAK;
         ST_BREAK:  if (rx_s) state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_CLK) begin
      if (!i_RESET_N) begin
         r_STATE       <= ST_IDLE;
         r_CLK_COUNT   <= '0;
         r_BIT_COUNT   <= '0;
         r_DATA_REG    <= '0;
         o_DATA_OUT    <= '0;
         o_DATA_VALID  <= 1'b0;
         o_FRAME_ERROR <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_PARITY_BIT   <= 1'b0;
         o_PARITY_ERROR <= 1'b0;
`endif
      end else begin
         r_STATE       <= state_next;
         o_DATA_VALID  <= 1'b0;
         o_FRAME_ERROR <= 1'b0;

         // The per-bit restart in DATA keeps every data sample CLKS_PER_BIT apart.
         if ((state_next != r_STATE) || data_sample)
            r_CLK_COUNT <= '0;
         else if (r_CLK_COUNT != CNT_MAX)
            r_CLK_COUNT <= r_CLK_COUNT + 1'b1;

         if (data_sample) begin
            r_DATA_REG  <= {rx_s, r_DATA_REG[UART_DATA_W-1:1]};
            r_BIT_COUNT <= r_BIT_COUNT + 1'b1;
         end

`ifdef UART_RX_PARITY_EN
         o_PARITY_ERROR <= 1'b0;
         if ((r_STATE == ST_PARITY) && at_last)
            r_PARITY_BIT <= rx_s;
`endif

         if (stop_sample) begin
            if (!rx_s)
               o_FRAME_ERROR <= 1'b1;
`ifdef UART_RX_PARITY_EN
            else if (^{r_DATA_REG, r_PARITY_BIT})
               o_PARITY_ERROR <= 1'b1;
`endif
            else begin
               o_DATA_OUT   <= r_DATA_REG;
               o_DATA_VALID <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at CLKS_PER_BIT=16: table of clean/bad-stop
// frames plus hand sequences for glitch, break, back-to-back, reset and enable.
module tb_uart_receiver;
   import uart_pkg::*;

   localparam int CPB = 16;
   // Frame cycle n is the clock period that follows edge n-1, where edge 0
   // captures the start bit; good data is then visible in cycle 4+7+9*16.
   localparam int VALID_OFS = 4 + (CPB - 1) / 2 + 9 * CPB;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       rx;
   logic [7:0] data_out;
   logic       valid;
   logic       ferr;
   logic       busy;
   logic [2:0] state;
`ifdef UART_RX_PARITY_EN
   logic       perr;
`endif

   always #5 clk = ~clk;

   uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
      .i_CLK          (clk),
      .i_RESET_N      (rst_n),
      .i_RX_ENABLE    (en),
      .i_RX           (rx),
      .o_DATA_OUT     (data_out),
      .o_DATA_VALID   (valid),
      .o_FRAME_ERROR  (ferr),
`ifdef UART_RX_PARITY_EN
      .o_PARITY_ERROR (perr),
`endif
      .o_RX_BUSY      (busy),
      .o_STATE        (state)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int frame_start = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Observed side of the scoreboard; only this process writes these.
   logic [7:0] got_q[$];
   int         got_cyc_q[$];
   int         ferr_cnt = 0;
   int         ferr_cyc = 0;
   int         perr_cnt = 0;
   int         both_cnt = 0;
   int         busy_rise_cnt = 0;
   int         busy_rise_cyc = 0;
   logic       busy_d = 1'b0;

   always @(negedge clk) begin
      if (valid) begin
         got_q.push_back(data_out);
         got_cyc_q.push_back(cyc);
      end
      if (ferr) begin
         ferr_cnt = ferr_cnt + 1;
         ferr_cyc = cyc;
      end
      if (valid && ferr) both_cnt = both_cnt + 1;
`ifdef UART_RX_PARITY_EN
      if (perr) perr_cnt = perr_cnt + 1;
`endif
      if (busy && !busy_d) begin
         busy_rise_cnt = busy_rise_cnt + 1;
         busy_rise_cyc = cyc;
      end
      busy_d = busy;
   end

   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Drives frame bits pat[0..nbits-1] (LSB first, start bit in pat[0]) for
   // frame cycles k0..k1-1; line idles high past the last bit.
   task automatic send(input logic [10:0] pat, input int nbits, input int k0, input int k1);
      for (int k = k0; k < k1; k++) begin
         @(negedge clk);
         if (k == 0) frame_start = cyc;
         rx = ((k / CPB) < nbits) ? pat[k / CPB] : 1'b1;
      end
   endtask

   task automatic line(input int n, input logic lvl);
      repeat (n) begin
         @(negedge clk);
         rx = lvl;
      end
   endtask

   function automatic logic [10:0] frame8(input logic [7:0] d, input logic stop);
      return {1'b1, stop, d, 1'b0};
   endfunction

   // Pops expected bytes and compares them with bytes observed since base.
   task automatic score(input string name, input int base);
      int i;
      i = base;
      while (exp_q.size() > 0) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         if (i < got_q.size()) chk(name, got_q[i], e);
         else chk({name, "_missing"}, 32'hFFFF_FFFF, e);
         i++;
      end
      chk({name, "_count"}, got_q.size() - base, i - base);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_valid;
      int         exp_ferr;
      logic [7:0] exp_out;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int base, f0, r0, sc;

      vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
      vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
      vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
      vecs[3] = '{8'hC3, 1'b0, 0, 1, 8'hFF};
      vecs[4] = '{8'h11, 1'b1, 1, 0, 8'h11};

      rst_n = 1'b0;
      en    = 1'b1;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_data_out", data_out, 8'h00);
      chk("reset_valid", valid, 1'b0);
      chk("reset_ferr", ferr, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_state", state, IDLE);
      rst_n = 1'b1;
      line(5, 1'b1);

      for (int v = 0; v < 5; v++) begin
         base = got_q.size();
         f0 = ferr_cnt;
         r0 = busy_rise_cnt;
         send(frame8(vecs[v].data, vecs[v].stop), 10, 0, 10 * CPB);
         sc = frame_start;
         line(20, 1'b1);
         if (vecs[v].exp_valid != 0) exp_q.push_back(vecs[v].data);
         score("vec_data", base);
         if (got_q.size() > base) chk("vec_valid_cycle", got_cyc_q[base] - sc, VALID_OFS);
         chk("vec_ferr_count", ferr_cnt - f0, vecs[v].exp_ferr);
         if (vecs[v].exp_ferr != 0) chk("vec_ferr_cycle", ferr_cyc - sc, VALID_OFS);
         chk("vec_data_out", data_out, vecs[v].exp_out);
         chk("vec_busy_rises", busy_rise_cnt - r0, 1);
         chk("vec_busy_rise_cycle", busy_rise_cyc - sc, 3);
         chk("vec_idle_state", state, IDLE);
         chk("vec_idle_busy", busy, 1'b0);
      end

      // Short low glitch: start bit rejected at its midpoint.
      base = got_q.size();
      f0 = ferr_cnt;
      r0 = busy_rise_cnt;
      line(4, 1'b0);
      line(30, 1'b1);
      chk("glitch_valid", got_q.size() - base, 0);
      chk("glitch_ferr", ferr_cnt - f0, 0);
      chk("glitch_busy_rises", busy_rise_cnt - r0, 1);
      chk("glitch_state", state, IDLE);
      chk("glitch_busy", busy, 1'b0);

      // Bad stop bit followed by a held-low line.
      base = got_q.size();
      f0 = ferr_cnt;
      r0 = busy_rise_cnt;
      send(frame8(8'h3C, 1'b0), 10, 0, 10 * CPB);
      sc = frame_start;
      line(48, 1'b0);
      chk("break_ferr_count", ferr_cnt - f0, 1);
      chk("break_ferr_cycle", ferr_cyc - sc, VALID_OFS);
      chk("break_state", state, BREAK);
      chk("break_busy", busy, 1'b1);
      chk("break_data_out", data_out, 8'h11);
      line(30, 1'b1);
      chk("break_exit_state", state, IDLE);
      chk("break_no_restart", busy_rise_cnt - r0, 1);
      chk("break_valid", got_q.size() - base, 0);

      // Back-to-back frames with zero idle gap.
      base = got_q.size();
      send(frame8(8'h00, 1'b1), 10, 0, 10 * CPB);
      sc = frame_start;
      send(frame8(8'hFF, 1'b1), 10, 0, 10 * CPB);
      line(20, 1'b1);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      score("b2b_data", base);
      if (got_q.size() >= base + 2) begin
         chk("b2b_first_cycle", got_cyc_q[base] - sc, VALID_OFS);
         chk("b2b_spacing", got_cyc_q[base + 1] - got_cyc_q[base], 10 * CPB);
      end

      // Reset pulse after data bit 3 of 0x5A; both ends reset, so the line idles.
      base = got_q.size();
      send(frame8(8'h5A, 1'b1), 10, 0, 5 * CPB);
      rst_n = 1'b0;
      rx    = 1'b1;
      @(negedge clk);
      chk("midreset_data_out", data_out, 8'h00);
      chk("midreset_valid", valid, 1'b0);
      chk("midreset_ferr", ferr, 1'b0);
      chk("midreset_busy", busy, 1'b0);
      chk("midreset_state", state, IDLE);
      rst_n = 1'b1;
      line(10, 1'b1);
      chk("midreset_no_5a", got_q.size() - base, 0);
      send(frame8(8'h81, 1'b1), 10, 0, 10 * CPB);
      line(20, 1'b1);
      exp_q.push_back(8'h81);
      score("postreset_data", base);

      // Enable low blocks detection; raising it with the line low starts at once.
      r0 = busy_rise_cnt;
      en = 1'b0;
      line(40, 1'b0);
      chk("disabled_no_start", busy_rise_cnt - r0, 0);
      chk("disabled_state", state, IDLE);
      en = 1'b1;
      @(negedge clk);
      chk("enable_rise_start", state, START);
      line(30, 1'b1);
      chk("enable_glitch_idle", state, IDLE);

      // Enable dropping mid-frame does not abort the frame.
      base = got_q.size();
      send(frame8(8'h96, 1'b1), 10, 0, 30);
      sc = frame_start;
      en = 1'b0;
      send(frame8(8'h96, 1'b1), 10, 30, 10 * CPB);
      line(20, 1'b1);
      en = 1'b1;
      exp_q.push_back(8'h96);
      score("enable_drop_data", base);
      if (got_q.size() > base) chk("enable_drop_cycle", got_cyc_q[base] - sc, VALID_OFS);

`ifdef UART_RX_PARITY_EN
      // 0x3E has five ones, so even parity requires a 1.
      base = got_q.size();
      f0 = perr_cnt;
      send({1'b1, 1'b0, 8'h3E, 1'b0}, 11, 0, 11 * CPB);
      line(20, 1'b1);
      chk("parity_err_count", perr_cnt - f0, 1);
      chk("parity_err_no_valid", got_q.size() - base, 0);
      chk("parity_err_data_hold", data_out, 8'h96);
      send({1'b1, 1'b1, 8'h3E, 1'b0}, 11, 0, 11 * CPB);
      sc = frame_start;
      line(20, 1'b1);
      exp_q.push_back(8'h3E);
      score("parity_ok_data", base);
      if (got_q.size() > base) chk("parity_ok_cycle", got_cyc_q[base] - sc, VALID_OFS + CPB);
      chk("parity_ok_no_err", perr_cnt - f0, 1);
`endif

      chk("valid_ferr_overlap", both_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
